channel_rx_cdr_slicer: RTL

// Receive-end counterpart of the oversampled channel model. Takes N samples/UI of

---
 rtl/channel_rx_cdr_slicer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/channel_rx_cdr_slicer.sv
// Oversampled receiver: 1-tap high-boost EQ, slicer, and bang-bang phase picker
// selecting one of N sample phases per UI, with vote filtering and lock detection.
module channel_rx_cdr_slicer #(
    parameter int N          = 10,
    parameter int DW         = 12,
    parameter int THRESH     = 2048,
    parameter int EQ_EN      = 1,
    parameter int EQ_SHIFT   = 1,
    parameter int VOTE       = 4,
    parameter int LOCK_EDGES = 8,
    parameter int PHASE_INIT = N / 2
) (
    input  logic                 Sample_CLK,
    input  logic                 Rst,
    input  logic [DW-1:0]        Sample_in,
    input  logic                 Sample_valid,
    output logic                 Data_out,
    output logic                 Data_valid,
    output logic [$clog2(N)-1:0] Phase_out,
    output logic                 Locked
);
    localparam int PW = $clog2(N);
    localparam int EW = DW + EQ_SHIFT + 2;
    localparam int SW = PW + 2;
    localparam int AW = $clog2(VOTE + 1) + 1;
    localparam int LW = $clog2(LOCK_EDGES + 1);

    localparam logic [PW-1:0]        LAST     = PW'(N - 1);
    localparam logic signed [EW-1:0] THR_S    = EW'(THRESH);
    localparam logic signed [SW-1:0] N_S      = SW'(N);
    localparam logic signed [SW-1:0] HALF_S   = SW'(N / 2);
    localparam logic signed [SW-1:0] ONE_S    = SW'(1);
    localparam logic signed [AW-1:0] VOTE_S   = AW'(VOTE);
    localparam logic signed [AW-1:0] ACC_ONE  = AW'(1);
    localparam logic [LW-1:0]        LOCK_MAX = LW'(LOCK_EDGES);

    typedef enum logic [1:0] {STEP_NONE, STEP_UP, STEP_DN} step_t;

    logic [PW-1:0]        cnt_q, cnt_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;
    logic [DW-1:0]        x_r_q, x_r_d, x_prev_q, x_prev_d;
    logic                 b2_q, b2_d, b2_prev_q, b2_prev_d;
    logic                 dout_q, dout_d, dvalid_q, dvalid_d, locked_q, locked_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic signed [AW-1:0] acc_q, acc_d, acc_nxt;
    step_t                pend_q, pend_d;
    logic [LW-1:0]        lockcnt_q, lockcnt_d;

    logic signed [EW-1:0] x_s, xp_s, diff_s, eq_s;
    logic signed [SW-1:0] tgt_s, err_s;
    logic                 edge_seen, err_near;

    always_comb begin
        cnt_d     = cnt_q;
        cnt1_d    = cnt1_q;
        cnt2_d    = cnt2_q;
        x_r_d     = x_r_q;
        x_prev_d  = x_prev_q;
        b2_d      = b2_q;
        b2_prev_d = b2_prev_q;
        dout_d    = dout_q;
        dvalid_d  = 1'b0;
        locked_d  = locked_q;
        phase_d   = phase_q;
        acc_d     = acc_q;
        acc_nxt   = acc_q;
        pend_d    = pend_q;
        lockcnt_d = lockcnt_q;

        x_s    = $signed({{(EW-DW){1'b0}}, x_r_q});
        xp_s   = $signed({{(EW-DW){1'b0}}, x_prev_q});
        diff_s = x_s - xp_s;
        eq_s   = (EQ_EN != 0) ? x_s + (diff_s <<< EQ_SHIFT) : x_s;

        // Ideal decision point sits half a UI from the observed edge; error is
        // wrapped so that exactly half a UI away counts as a down vote.
        tgt_s = $signed({2'b00, cnt2_q}) + HALF_S;
        if (tgt_s >= N_S) tgt_s = tgt_s - N_S;
        err_s = tgt_s - $signed({2'b00, phase_q});
        if (err_s >= HALF_S) err_s = err_s - N_S;
        else if (err_s < -HALF_S) err_s = err_s + N_S;

        edge_seen = (b2_q != b2_prev_q);
        err_near  = (err_s >= -ONE_S) && (err_s <= ONE_S);

        if (Sample_valid) begin
            cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + PW'(1);
            x_r_d     = Sample_in;
            x_prev_d  = x_r_q;
            cnt1_d    = cnt_q;
            b2_d      = (eq_s >= THR_S);
            b2_prev_d = b2_q;
            cnt2_d    = cnt1_q;

            if (cnt2_q == phase_q) begin
                dout_d   = b2_q;
                dvalid_d = 1'b1;
            end

            // Steps land only at the UI boundary so the decision compare above
            // always sees the phase that was in force for this sample.
            if (cnt2_q == LAST && pend_q != STEP_NONE) begin
                if (pend_q == STEP_UP) phase_d = (phase_q == LAST) ? '0 : phase_q + PW'(1);
                else                   phase_d = (phase_q == '0) ? LAST : phase_q - PW'(1);
                pend_d = STEP_NONE;
            end

            if (edge_seen) begin
                if (err_s[SW-1])       acc_nxt = acc_q - ACC_ONE;
                else if (err_s != '0)  acc_nxt = acc_q + ACC_ONE;
                if (acc_nxt == VOTE_S) begin
                    pend_d = STEP_UP;
                    acc_d  = '0;
                end else if (acc_nxt == -VOTE_S) begin
                    pend_d = STEP_DN;
                    acc_d  = '0;
                end else begin
                    acc_d = acc_nxt;
                end

                if (err_near) begin
                    if (lockcnt_q != LOCK_MAX) lockcnt_d = lockcnt_q + LW'(1);
                    locked_d = (lockcnt_d == LOCK_MAX);
                end else begin
                    lockcnt_d = '0;
                    locked_d  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge Sample_CLK or posedge Rst) begin
        if (Rst) begin
            cnt_q     <= '0;
            cnt1_q    <= '0;
            cnt2_q    <= '0;
            x_r_q     <= '0;
            x_prev_q  <= '0;
            b2_q      <= 1'b0;
            b2_prev_q <= 1'b0;
            dout_q    <= 1'b0;
            dvalid_q  <= 1'b0;
            locked_q  <= 1'b0;
            phase_q   <= PW'(PHASE_INIT);
            acc_q     <= '0;
            pend_q    <= STEP_NONE;
            lockcnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            cnt1_q    <= cnt1_d;
            cnt2_q    <= cnt2_d;
            x_r_q     <= x_r_d;
            x_prev_q  <= x_prev_d;
            b2_q      <= b2_d;
            b2_prev_q <= b2_prev_d;
            dout_q    <= dout_d;
            dvalid_q  <= dvalid_d;
            locked_q  <= locked_d;
            phase_q   <= phase_d;
            acc_q     <= acc_d;
            pend_q    <= pend_d;
            lockcnt_q <= lockcnt_d;
        end
    end

    assign Data_out   = dout_q;
    assign Data_valid = dvalid_q;
    assign Phase_out  = phase_q;
    assign Locked     = locked_q;

endmodule
